// File: rtl/program_memory_if.sv
// program_memory_if: fetch port and loader handshake between CPU/loader (master) and program_memory (slave)
interface program_memory_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              loading;
  logic [ADDR_W:0]   load_count;
  logic              load_overflow;
  logic              parity_err;
  modport master (
    output fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    input  fetch_data, fetch_valid, load_ready, loading, load_count, load_overflow, parity_err
  );
  modport slave (
    input  fetch_en, fetch_addr, load_start, load_valid, load_data, load_last,
    output fetch_data, fetch_valid, load_ready, loading, load_count, load_overflow, parity_err
  );
endinterface

// File: rtl/program_memory.sv
// program_memory: loadable CPU program store; ports clk, reset, bus (program_memory_if.slave: registered fetch port + clear-then-load byte loader); PROG_MEM_PARITY_EN adds per-word even parity
module program_memory #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH = 32,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input logic clk,
  input logic reset,
  program_memory_if.slave bus
);
`ifdef PROG_MEM_PARITY_EN
  localparam int W = DATA_W + 1;
`else
  localparam int W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] last_addr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] depth_w = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {RUN, CLEAR, LOAD, DRAIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd, wd;
  logic [DATA_W-1:0] wdat;
  logic we, acc, in_range;
  always_comb begin
    acc = bus.load_valid & bus.load_ready;
    we = !reset && !bus.load_start && (state == CLEAR || (state == LOAD && acc));
    wdat = state == CLEAR ? FILL : bus.load_data;
    in_range = {1'b0, bus.fetch_addr} < depth_w;
    rd = in_range ? mem[bus.fetch_addr] : '0;
  end
`ifdef PROG_MEM_PARITY_EN
  assign wd = {^wdat, wdat};
`else
  assign wd = wdat;
`endif
  always_ff @(posedge clk)
    if (we) mem[ptr] <= wd;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      ptr <= '0;
      bus.fetch_data <= '0;
      bus.fetch_valid <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.loading <= 1'b0;
      bus.load_count <= '0;
      bus.load_overflow <= 1'b0;
      bus.parity_err <= 1'b0;
    end else if (bus.load_start) begin
      state <= CLEAR;
      ptr <= '0;
      bus.fetch_valid <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.loading <= 1'b1;
      bus.load_count <= '0;
      bus.load_overflow <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.fetch_valid <= state == RUN && bus.fetch_en;
      if (state == RUN && bus.fetch_en) begin
        bus.fetch_data <= in_range ? rd[DATA_W-1:0] : FILL;
`ifdef PROG_MEM_PARITY_EN
        bus.parity_err <= bus.parity_err | (in_range & ^rd);
`endif
      end
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == last_addr) begin
            state <= LOAD;
            ptr <= '0;
            bus.load_ready <= 1'b1;
          end
        end
        LOAD: if (acc) begin
          ptr <= ptr + 1'b1;
          bus.load_count <= bus.load_count + 1'b1;
          if (bus.load_last) begin
            state <= RUN;
            bus.load_ready <= 1'b0;
            bus.loading <= 1'b0;
          end else if (ptr == last_addr) state <= DRAIN;
        end
        DRAIN: if (acc) begin
          bus.load_overflow <= 1'b1;
          if (bus.load_last) begin
            state <= RUN;
            bus.load_ready <= 1'b0;
            bus.loading <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_program_memory.sv
// tb_program_memory: table-driven fetch vectors with a scoreboard queue, plus loader/reset/parity sequences
module tb_program_memory;
  localparam logic [7:0] F1 = 8'h5A;
  localparam logic [7:0] F2 = 8'hA5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  program_memory_if #(.ADDR_W(5), .DATA_W(8)) b ();
  program_memory_if #(.ADDR_W(5), .DATA_W(8)) b2 ();
  program_memory #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .FILL(F1)) dut (.clk(clk), .reset(reset), .bus(b));
  program_memory #(.ADDR_W(5), .DATA_W(8), .DEPTH(20), .FILL(F2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  typedef struct {
    logic [4:0] addr;
    logic [7:0] exp;
  } fv_t;
  fv_t tbl[$];
  logic [7:0] expq[$];
  logic [7:0] prog[$];
  int checks = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic add(input logic [4:0] a, input logic [7:0] e);
    fv_t v;
    v.addr = a;
    v.exp = e;
    tbl.push_back(v);
  endtask
  always @(negedge clk)
    if (b.fetch_valid === 1'b1) begin
      if (expq.size() == 0) chk("unexpected_fetch_valid", b.fetch_valid, 0);
      else chk("fetch_data", b.fetch_data, expq.pop_front());
    end
  task automatic start_load;
    int n = 0;
    b.load_start = 1'b1;
    tick;
    b.load_start = 1'b0;
    b.load_valid = 1'b0;
    b.load_last = 1'b0;
    chk("loading_after_start", b.loading, 1);
    chk("count_after_start", b.load_count, 0);
    while (!b.load_ready && n < 100) begin
      n++;
      tick;
    end
    chk("clear_cycles", n, 32);
  endtask
  task automatic send(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      b.load_valid = 1'b1;
      b.load_data = prog[i];
      b.load_last = with_last && i == n - 1;
      tick;
      chk("overflow_step", b.load_overflow, i >= 32);
      chk("load_count_step", b.load_count, (i + 1 > 32) ? 32 : i + 1);
    end
    b.load_valid = 1'b0;
    b.load_last = 1'b0;
  endtask
  task automatic fetch_tbl;
    foreach (tbl[i]) begin
      b.fetch_en = 1'b1;
      b.fetch_addr = tbl[i].addr;
      expq.push_back(tbl[i].exp);
      tick;
    end
    b.fetch_en = 1'b0;
    tick;
    chk("fetch_valid_drop", b.fetch_valid, 0);
    chk("fetch_hold", b.fetch_data, tbl[tbl.size() - 1].exp);
    chk("queue_drained", expq.size(), 0);
    tbl.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    {b.fetch_en, b.fetch_addr, b.load_start, b.load_valid, b.load_data, b.load_last} = '0;
    {b2.fetch_en, b2.fetch_addr, b2.load_start, b2.load_valid, b2.load_data, b2.load_last} = '0;
    repeat (3) tick;
    chk("rst_fetch_data", b.fetch_data, 0);
    chk("rst_fetch_valid", b.fetch_valid, 0);
    chk("rst_load_ready", b.load_ready, 0);
    chk("rst_loading", b.loading, 0);
    chk("rst_load_count", b.load_count, 0);
    chk("rst_overflow", b.load_overflow, 0);
    chk("rst_parity", b.parity_err, 0);
    reset = 1'b0;
    tick;
    prog = '{8'h35, 8'h00, 8'h33};
    start_load;
    send(3, 1);
    chk("load3_loading", b.loading, 0);
    chk("load3_ready", b.load_ready, 0);
    chk("load3_count", b.load_count, 3);
    add(0, 8'h35); add(1, 8'h00); add(2, 8'h33); add(3, F1); add(31, F1);
    fetch_tbl;
    prog.delete();
    for (int i = 0; i < 40; i++) prog.push_back(8'h80 + 8'(i));
    start_load;
    send(40, 1);
    chk("ovf_count", b.load_count, 32);
    chk("ovf_flag", b.load_overflow, 1);
    chk("ovf_loading", b.loading, 0);
    add(0, 8'h80); add(12, 8'h8C); add(30, 8'h9E); add(31, 8'h9F);
    fetch_tbl;
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(8'h40 + 8'(i));
    start_load;
    send(5, 0);
    chk("mid_load_count", b.load_count, 5);
    b.load_valid = 1'b1;
    b.load_data = 8'hEE;
    b.load_last = 1'b1;
    start_load;
    prog = '{8'h11, 8'h22};
    send(2, 1);
    chk("restart_count", b.load_count, 2);
    chk("restart_overflow", b.load_overflow, 0);
    add(0, 8'h11); add(1, 8'h22); add(2, F1); add(4, F1);
    fetch_tbl;
    prog.delete();
    for (int i = 0; i < 16; i++) prog.push_back(8'h60 + 8'(i));
    start_load;
    send(16, 1);
    b.load_start = 1'b1;
    tick;
    b.load_start = 1'b0;
    repeat (10) tick;
    chk("clear_before_reset", b.loading, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rclr_loading", b.loading, 0);
    chk("rclr_fetch_valid", b.fetch_valid, 0);
    chk("rclr_load_count", b.load_count, 0);
    chk("rclr_load_ready", b.load_ready, 0);
    add(12, 8'h6C); add(11, 8'h6B); add(15, 8'h6F); add(3, F1); add(9, F1); add(0, F1);
    fetch_tbl;
    b2.fetch_en = 1'b1;
    b2.fetch_addr = 5'd25;
    tick;
    chk("d20_valid_25", b2.fetch_valid, 1);
    chk("d20_data_25", b2.fetch_data, F2);
    b2.load_start = 1'b1;
    b2.fetch_en = 1'b0;
    tick;
    b2.load_start = 1'b0;
    n = 0;
    while (!b2.load_ready && n < 100) begin
      n++;
      tick;
    end
    chk("d20_clear_cycles", n, 20);
    b2.load_valid = 1'b1;
    b2.load_data = 8'h77;
    b2.load_last = 1'b1;
    tick;
    b2.load_valid = 1'b0;
    b2.load_last = 1'b0;
    chk("d20_count", b2.load_count, 1);
    b2.fetch_en = 1'b1;
    b2.fetch_addr = 5'd0;
    tick;
    chk("d20_data_0", b2.fetch_data, 8'h77);
    b2.fetch_addr = 5'd19;
    tick;
    chk("d20_data_19", b2.fetch_data, F2);
    b2.fetch_addr = 5'd20;
    tick;
    chk("d20_data_20", b2.fetch_data, F2);
    chk("d20_valid_20", b2.fetch_valid, 1);
    b2.fetch_en = 1'b0;
    tick;
    chk("d20_valid_drop", b2.fetch_valid, 0);
`ifdef PROG_MEM_PARITY_EN
    chk("par_clean", b.parity_err, 0);
    dut.mem[2] <= dut.mem[2] ^ 9'h100;
    tick;
    b.fetch_en = 1'b1;
    b.fetch_addr = 5'd2;
    expq.push_back(F1);
    tick;
    chk("par_set", b.parity_err, 1);
    b.fetch_addr = 5'd0;
    expq.push_back(F1);
    tick;
    chk("par_sticky", b.parity_err, 1);
    b.fetch_en = 1'b0;
    tick;
    chk("par_queue", expq.size(), 0);
    b.load_start = 1'b1;
    tick;
    b.load_start = 1'b0;
    chk("par_cleared", b.parity_err, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/program_memory.md
# program_memory

Parametrised, loadable program store for the nibble CPU, replacing fixed case-table instruction ROMs. The CPU fetches instruction bytes through a registered read port. A byte-stream loader port, with a valid/ready handshake, clears the memory and then writes a new program without resynthesis. The block sits between the CPU fetch stage and the board-level program loader.

## Interface
- ADDR_W, 5, fetch/load address width
- DATA_W, 8, instruction word width
- DEPTH, 32, number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- FILL, 0, DATA_W-bit value used for clearing and returned for out-of-range fetches
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- fetch_en  in  1  fetch request, sampled in RUN only
- fetch_addr  in  ADDR_W  fetch address
- fetch_data  out  DATA_W  registered read data
- fetch_valid  out  1  fetch_data updated this cycle
- load_start  in  1  pulse: begin clear-then-load sequence
- load_valid  in  1  loader word present
- load_data  in  DATA_W  loader word
- load_last  in  1  qualifies final word of program
- load_ready  out  1  block accepts a loader word
- loading  out  1  state ≠ RUN
- load_count  out  ADDR_W+1  words written in current/last load
- load_overflow  out  1  sticky: program exceeded DEPTH
- parity_err  out  1  fetched word failed parity (see Configuration)

## Operation
- States: RUN, CLEAR, LOAD, DRAIN. Reset → RUN.
- Accept = load_valid & load_ready.
- load_ready = 1 in LOAD and DRAIN, otherwise 0.
- RUN
  - fetch_en=1 → next cycle: fetch_data = mem[fetch_addr], or FILL if fetch_addr ≥ DEPTH; fetch_valid=1.
  - fetch_en=0 → fetch_valid=0; fetch_data holds its previous value.
- load_start in any state → CLEAR.
  - Clear pointer := 0, load_count := 0, load_overflow := 0, parity_err := 0.
  - load_start has priority over fetch_en and over a same-cycle accept; that word is dropped.
- CLEAR
  - Writes FILL to address ptr each cycle; ptr increments.
  - After writing address DEPTH-1 → LOAD with write pointer = 0.
- LOAD
  - Each accept writes load_data at the pointer, then pointer and load_count increment.
  - Accept with load_last=1 → RUN.
  - Accept at address DEPTH-1 with load_last=0 → DRAIN.
- DRAIN
  - Accepted words are discarded.
  - load_overflow := 1 on the first discarded word; load_count does not change.
  - Accept with load_last=1 → RUN.
- Outside RUN: fetch_valid=0; fetch_data holds.
- Reset mid-operation → RUN immediately.
  - Memory contents are not reset; a partial load or partial clear remains.
  - All output registers take their reset values.
- Reset values: fetch_data=0, fetch_valid=0, load_ready=0, loading=0, load_count=0, load_overflow=0, parity_err=0.

## Timing
- Fetch latency: 1 cycle (request at cycle t → data/valid at t+1).
  - Back-to-back fetches give one result per cycle.
- load_start sampled at cycle t:
  - loading=1 from t+1.
  - CLEAR occupies cycles t+1 … t+DEPTH.
  - LOAD from t+DEPTH+1, with load_ready=1 that cycle.
- A word is written on the edge where it is accepted.
- Final accept (load_last) at cycle u:
  - state=RUN and loading=0 at u+1.
  - A fetch requested at u+1 returns the new contents at u+2.
- load_count is valid for software readback once loading=0; it saturates at DEPTH.

## Configuration
- PROG_MEM_PARITY_EN defined:
  - Each word is stored as DATA_W+1 bits; the extra bit is even parity over the data, computed on every write, including CLEAR.
  - On each RUN fetch, parity is recomputed; a mismatch sets parity_err in the same cycle as fetch_valid.
  - parity_err is sticky until reset or load_start.
  - fetch_data still returns the stored data bits.
- Not defined: storage is DATA_W bits and parity_err is constant 0.

## Test plan
- Reset, then load_start with DEPTH=32: no load_ready during cycles t+1…t+32; load_ready=1 at t+33. Load 8'h35, 8'h00, 8'h33 (last) → load_count=3, loading=0. Fetch addr 0,1,2,3 → 8'h35, 8'h00, 8'h33, FILL on consecutive cycles with fetch_valid=1.
- Load 40 words with load_last on word 40 → words 0–31 stored; load_overflow=1 after word 33 is accepted; load_count=32; RUN after word 40.
- DEPTH=20, ADDR_W=5: fetch addr 25 → FILL, fetch_valid=1.
- Assert load_start mid-LOAD after 5 words → CLEAR restarts; fetch addr 4 after the new load of 2 words → FILL.
- Assert reset during CLEAR at ptr=10 → RUN next cycle; fetch_valid, loading, and load_count all 0. Fetch addr 12 returns pre-load contents; fetch addr 3 returns FILL.
- With PROG_MEM_PARITY_EN: force a single bit flip in stored word 2, then fetch addr 2 → parity_err=1 with fetch_valid and stays 1. A following load_start clears it to 0.
